// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator: per-channel off/on/slow/fast blink,
// fixed-duty PWM dim and triangle-ramped breathing, one registered output per LED.
module led_pattern_ctrl #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 30,
    parameter int HALF_SLOW    = 50000000,
    parameter int HALF_FAST    = 5000000,
    parameter int PWM_W        = 8,
    parameter int BREATHE_STEP = 200000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [3*N_CH-1:0]   mode,
    input  logic [PWM_W-1:0]    duty,
    output logic [N_CH-1:0]     led
);

    typedef enum logic [2:0] {
        M_HOLD    = 3'd0,
        M_SLOW    = 3'd1,
        M_FAST    = 3'd2,
        M_ON      = 3'd3,
        M_OFF     = 3'd4,
        M_DIM     = 3'd5,
        M_BREATHE = 3'd6,
        M_HOLD7   = 3'd7
    } mode_e;

    localparam logic [CNT_W-1:0] SLOW_LAST    = CNT_W'(HALF_SLOW - 1);
    localparam logic [CNT_W-1:0] FAST_LAST    = CNT_W'(HALF_FAST - 1);
    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(BREATHE_STEP - 1);
    localparam logic [PWM_W-1:0] PWM_MAX      = '1;

    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PWM_W-1:0] r_duty_q;

    // Shared PWM timebase; duty is sampled only at the frame boundary so a
    // DIM channel never sees a width change part-way through a frame.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pwm_cnt <= '0;
            r_duty_q  <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            if (r_pwm_cnt == PWM_MAX)
                r_duty_q <= duty;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        mode_e             w_req;
        mode_e             r_am;
        logic [CNT_W-1:0]  r_cnt;
        logic [CNT_W-1:0]  w_last;
        logic [PWM_W-1:0]  r_level;
        logic              r_dir_down;
        logic              r_led;
        logic              w_load;
        logic              w_hit;

        assign w_req  = mode_e'(mode[3*gi +: 3]);
        assign w_load = (w_req != M_HOLD) && (w_req != M_HOLD7) && (w_req != r_am);
        assign w_hit  = (r_cnt == w_last);
        assign led[gi] = r_led;

        // NOTE: every combinational output gets a default first so no latch is inferred.
        always_comb begin
            w_last = STEP_LAST;
            case (r_am)
                M_SLOW:  w_last = SLOW_LAST;
                M_FAST:  w_last = FAST_LAST;
                default: w_last = STEP_LAST;
            endcase
        end

        // A mode load wins over any toggle/step due in the same cycle.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_am       <= M_OFF;
                r_cnt      <= '0;
                r_level    <= '0;
                r_dir_down <= 1'b0;
                r_led      <= 1'b0;
            end else if (w_load) begin
                r_am       <= w_req;
                r_cnt      <= '0;
                r_level    <= '0;
                r_dir_down <= 1'b0;
                r_led      <= (w_req == M_SLOW) || (w_req == M_FAST) || (w_req == M_ON);
            end else begin
                case (r_am)
                    M_SLOW, M_FAST: begin
                        if (w_hit) begin
                            r_cnt <= '0;
                            r_led <= ~r_led;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    M_ON:  r_led <= 1'b1;
                    M_OFF: r_led <= 1'b0;
                    M_DIM: r_led <= (r_pwm_cnt < r_duty_q);
                    M_BREATHE: begin
                        r_led <= (r_pwm_cnt < r_level);
                        if (w_hit) begin
                            r_cnt <= '0;
                            // Reverse at the endpoints so each extreme lasts one step.
                            if (!r_dir_down) begin
                                if (r_level == PWM_MAX) begin
                                    r_dir_down <= 1'b1;
                                    r_level    <= r_level - PWM_W'(1);
                                end else begin
                                    r_level    <= r_level + PWM_W'(1);
                                end
                            end else begin
                                if (r_level == '0) begin
                                    r_dir_down <= 1'b0;
                                    r_level    <= r_level + PWM_W'(1);
                                end else begin
                                    r_level    <= r_level - PWM_W'(1);
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_led <= r_led;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: time-based reference model
// (elapsed cycles since each mode load) compared against led every cycle.
module tb_led_pattern_ctrl;

    localparam int N_CH         = 2;
    localparam int CNT_W        = 30;
    localparam int HALF_SLOW    = 8;
    localparam int HALF_FAST    = 2;
    localparam int PWM_W        = 3;
    localparam int BREATHE_STEP = 2;
    localparam int FRAME        = 1 << PWM_W;
    localparam int MAXL         = FRAME - 1;

    logic                clk = 1'b0;
    logic                rstn;
    logic [3*N_CH-1:0]   mode;
    logic [PWM_W-1:0]    duty;
    logic [N_CH-1:0]     led;

    int errors = 0;
    int checks = 0;

    // Model state: edge index since reset release, per-channel active mode
    // and load edge, and the duty value in force for the current frame.
    int n;
    int m_am [N_CH];
    int m_t0 [N_CH];
    int m_dq;

    led_pattern_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .HALF_SLOW(HALF_SLOW), .HALF_FAST(HALF_FAST),
        .PWM_W(PWM_W), .BREATHE_STEP(BREATHE_STEP)
    ) dut (
        .clk(clk), .rstn(rstn), .mode(mode), .duty(duty), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Breathe level after k steps: triangle 0..MAXL..1 with period 2*MAXL.
    function automatic int tri_lvl(input int k);
        int m;
        m = k % (2 * MAXL);
        return (m <= MAXL) ? m : 2 * MAXL - m;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        mode = '0;
        duty = '0;
        #12;
        check("in_reset", 32'(led), 32'(0));
        n    = 0;
        m_dq = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_am[c] = 4;
            m_t0[c] = 0;
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Predict led after the next edge from current inputs, then sample it.
    task automatic step(input string tag);
        logic [N_CH-1:0] exp;
        int pre, req, e;
        exp = '0;
        n++;
        pre = (n - 1) % FRAME;
        for (int c = 0; c < N_CH; c++) begin
            req = int'(mode[3*c +: 3]);
            if (req != 0 && req != 7 && req != m_am[c]) begin
                m_am[c] = req;
                m_t0[c] = n;
                exp[c]  = (req == 1 || req == 2 || req == 3);
            end else begin
                e = n - m_t0[c];
                case (m_am[c])
                    1: exp[c] = ((e / HALF_SLOW) % 2) == 0;
                    2: exp[c] = ((e / HALF_FAST) % 2) == 0;
                    3: exp[c] = 1'b1;
                    5: exp[c] = pre < m_dq;
                    6: exp[c] = pre < tri_lvl((e - 1) / BREATHE_STEP);
                    default: exp[c] = 1'b0;
                endcase
            end
        end
        if (pre == MAXL)
            m_dq = int'(duty);
        @(posedge clk);
        #1;
        check(tag, 32'(led), 32'(exp));
    endtask

    task automatic run(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++)
            step(tag);
    endtask

    // Count ch0 high cycles over one full PWM frame; optionally change duty mid-frame.
    task automatic dim_frame(input string tag, input int exp_hi, input int new_duty);
        int hi;
        hi = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k == FRAME / 2 && new_duty >= 0)
                duty = PWM_W'(new_duty);
            step(tag);
            hi += int'(led[0]);
        end
        check({tag, "_hi"}, 32'(hi), 32'(exp_hi));
    endtask

    initial begin
        // 1: idle after reset, then asynchronous reset in the middle of a blink
        do_reset();
        run("idle", 20);
        mode = 6'o01;
        step("rst_blink_load");
        mode = '0;
        run("rst_blink", 3);
        check("pre_rst_lit", 32'(led[0]), 32'(1));
        #2 rstn = 1'b0;
        #1 check("async_rst", 32'(led), 32'(0));
        do_reset();
        run("idle2", 5);

        // 2: slow on ch0, fast on ch1, re-request of SLOW must not shift phase
        mode = 6'o21;
        step("blink_load");
        mode = '0;
        for (int k = 0; k < 40; k++) begin
            mode = (k == 13 || k == 22) ? 6'o01 : 6'o00;
            step("blink");
        end
        mode = '0;

        // 5: ON then OFF; SLOW->FAST switch on the toggle cycle
        mode = 6'o03; step("on_load");
        mode = '0;    run("on", 3);
        mode = 6'o04; step("off_load");
        check("off_fell", 32'(led[0]), 32'(0));
        mode = 6'o01; step("slow_load");
        mode = '0;    run("slow_pre", HALF_SLOW - 1);
        mode = 6'o02; step("slow2fast");
        check("slow2fast_lit", 32'(led[0]), 32'(1));
        mode = '0;    run("fast", 9);

        // 3: DIM with duty 3, mid-frame change to 6, then duty 0
        duty = 3'd3;
        mode = 6'o05; step("dim_load");
        mode = '0;
        while ((n % FRAME) != 0) step("dim_align");
        run("dim_settle", FRAME);
        dim_frame("dim3", 3, 6);
        dim_frame("dim6", 6, 0);
        dim_frame("dim0", 0, -1);

        // 4: BREATHE on ch1 through a full up/down cycle and beyond
        mode = 6'o60; step("breathe_load");
        mode = '0;
        run("breathe", 4 * MAXL * BREATHE_STEP + 6);

        // 6: concurrent SLOW + BREATHE, then randomized mode/duty traffic
        mode = 6'o61; step("concurrent_load");
        mode = '0;
        run("concurrent", 80);
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N_CH; c++)
                mode[3*c +: 3] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            duty = PWM_W'($urandom_range(0, MAXL));
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Multi-channel LED pattern generator. It is the parametrised successor of the single-channel blink controller. Each channel independently selects off, on, slow blink, fast blink, fixed-duty PWM dim, or breathing (triangle-ramped PWM). It sits between the front-panel mode/status logic and the board LED pins, and has one registered output per LED.

Parameters:
N_CH, 4, number of LED channels
CNT_W, 30, width of per-channel period counters
HALF_SLOW, 50000000, slow-blink half-period in clk cycles (>=1, < 2^CNT_W)
HALF_FAST, 5000000, fast-blink half-period in clk cycles (>=1, < 2^CNT_W)
PWM_W, 8, PWM resolution; PWM frame = 2^PWM_W cycles
BREATHE_STEP, 200000, clk cycles per breathe level step (>=1, < 2^CNT_W)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
mode  input  3*N_CH  per-channel mode request, channel i at bits [3i+2:3i]
duty  input  PWM_W  shared duty for DIM mode
led  output  N_CH  registered LED drive, 1 = lit

Behaviour:
- Clock and reset: clk is the clock; rstn is an asynchronous, active-low reset.
- Mode codes: 0 HOLD, 1 SLOW, 2 FAST, 3 ON, 4 OFF, 5 DIM, 6 BREATHE, 7 HOLD.
- Reset state:
  - led = 0.
  - Every active mode am[i] = OFF.
  - All counters = 0; breathe level = 0; breathe direction = up.
  - pwm_cnt = 0; duty_q = 0.
- Mode capture, each cycle per channel:
  - mode[i] of 0 or 7: am[i] is unchanged.
  - Otherwise, if mode[i] != am[i]: load am[i], clear cnt[i], level[i] = 0, dir[i] = up.
  - Re-requesting the current mode has no effect; the counter is not restarted.
- Latency: a new mode shows on led[i] at the clock edge after the cycle in which mode[i] is sampled (1 cycle).
- Start values on load: SLOW/FAST → led = 1; ON → 1; OFF → 0; DIM/BREATHE → follows the PWM compare from the next cycle.
- SLOW/FAST:
  - cnt[i] increments every cycle.
  - When cnt[i] == HALF-1: led[i] toggles and cnt[i] = 0.
  - Period = 2*HALF cycles, 50% duty. First toggle occurs HALF cycles after the load edge.
- PWM base:
  - One shared free-running pwm_cnt (PWM_W bits) wraps from 2^PWM_W-1 to 0.
  - duty_q captures duty only on the cycle where pwm_cnt == 2^PWM_W-1, so duty never changes mid-frame.
- DIM: led[i] = (pwm_cnt < duty_q), registered. duty_q = 0 → always off. duty_q = 2^PWM_W-1 → off 1 cycle per frame.
- BREATHE:
  - cnt[i] counts to BREATHE_STEP-1, then clears and steps level[i] by 1 in dir[i].
  - At level == 2^PWM_W-1 while going up: next step sets dir = down and level decrements.
  - At level == 0 while going down: dir = up and level increments.
  - Endpoints appear for one step only.
  - led[i] = (pwm_cnt < level[i]).
- Channels are fully independent, except for the shared pwm_cnt and duty_q.
- Counter widths: no overflow possible, since every compare target is < 2^CNT_W. Out-of-range parameters are unsupported.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronously), and led = 0 while rstn is low.
- Simultaneous events: a mode change on the same cycle as a toggle or step condition takes precedence; the counter clears and the start value applies.

Test Plan:
Bench configuration for all scenarios: N_CH=2, HALF_SLOW=8, HALF_FAST=2, PWM_W=3, BREATHE_STEP=2.
1. Reset then mode=0 → led=00 held indefinitely. Assert rstn low mid-blink → led=0 in the same cycle, not at an edge.
2. ch0 mode=1 for 1 cycle, then HOLD → led[0]=1 one edge later; toggles every 8 cycles (period 16). ch1 mode=2 → period 4. Re-driving mode=1 mid-period does not shift the phase.
3. ch0 DIM with duty=3 → led[0] high for exactly 3 of every 8 cycles. Change duty to 6 mid-frame → new width takes effect only from the next frame. duty=0 → never high.
4. ch1 BREATHE → level sequence 0,1,...,7,6,...,0,1 with one step per 2 cycles. Per-frame high count matches the level at each compare.
5. ch0 ON, then mode=4 → led[0] falls one edge later. Switching SLOW→FAST on a toggle cycle → the counter restarts and led=1.
6. Both channels in different modes concurrently (SLOW, BREATHE) → each matches its standalone reference model cycle-for-cycle.
